// File: rtl/seq_det_pkg.sv
// Shared types and default sizes for the programmable serial sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned DEF_PAT_W = 4;
  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned DEF_TO_W  = 6;

endpackage

// File: rtl/seq_pattern_matcher.sv
// Serial history shift register with fill tracking and pattern comparator.
module seq_pattern_matcher
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             shift,
  input  logic             clr_all,
  input  logic             clr_fill,
  input  logic             x,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit_c,
  output logic             full_c
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  // Only the newest PAT_W-1 bits are kept; the incoming bit completes the window.
  logic [PAT_W-2:0] hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0] window_c;

  assign window_c = {hist, x};
  assign full_c   = shift && (fill >= FILL_W'(PAT_W - 1));
  assign hit_c    = full_c && (window_c == pattern);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clr_all) begin
      hist <= '0;
      fill <= '0;
    end else begin
      if (shift) hist <= window_c[PAT_W-2:0];
      if (clr_fill) fill <= '0;
      else if (shift && (fill != FILL_W'(PAT_W))) fill <= fill + FILL_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run-time controller for a programmable serial sequence detector.
// Optional idle-stream timeout enabled by defining SEQ_CTRL_TIMEOUT_EN.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W,
  parameter int unsigned CNT_W = DEF_CNT_W
`ifdef SEQ_CTRL_TIMEOUT_EN
  , parameter int unsigned TO_W = DEF_TO_W
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             x_valid,
  input  logic             x,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
`ifdef SEQ_CTRL_TIMEOUT_EN
  , output logic           timeout
`endif
);

  state_t           state, state_d;
  logic [PAT_W-1:0] pattern, pattern_d;
  logic             overlap, overlap_d;
  logic [CNT_W-1:0] target, target_d;
  logic [CNT_W-1:0] count_d;
  logic             match_d, cfg_err_d;
  logic             shift, clr_all, clr_fill;
  logic             hit_c, full_c;
`ifdef SEQ_CTRL_TIMEOUT_EN
  logic [TO_W-1:0]  to_cnt, to_cnt_d;
  logic             timeout_d;
`endif

  seq_pattern_matcher #(.PAT_W(PAT_W)) u_matcher (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift    (shift),
    .clr_all  (clr_all),
    .clr_fill (clr_fill),
    .x        (x),
    .pattern  (pattern),
    .hit_c    (hit_c),
    .full_c   (full_c)
  );

  // Next-state, configuration and counter update.
  always_comb begin
    state_d   = state;
    pattern_d = pattern;
    overlap_d = overlap;
    target_d  = target;
    count_d   = match_count;
    match_d   = 1'b0;
    cfg_err_d = 1'b0;
    shift     = 1'b0;
    clr_all   = 1'b0;
    clr_fill  = 1'b0;
`ifdef SEQ_CTRL_TIMEOUT_EN
    to_cnt_d  = '0;
    timeout_d = 1'b0;
`endif
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A same-edge write lands first, so start sees the new target.
          if (cfg_we) begin
            pattern_d = cfg_pattern;
            overlap_d = cfg_overlap;
            target_d  = cfg_target;
          end
          if (start) begin
            if (target_d != '0) begin
              clr_all = 1'b1;
              count_d = '0;
              state_d = FILL;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        FILL, RUN: begin
          cfg_err_d = cfg_we;
          shift     = x_valid;
          if (hit_c) begin
            match_d = 1'b1;
            count_d = match_count + CNT_W'(1);
            if (count_d == target) begin
              state_d = DONE;
            end else if (!overlap) begin
              clr_fill = 1'b1;
              state_d  = FILL;
            end else begin
              state_d = RUN;
            end
          end else if (full_c) begin
            state_d = RUN;
          end
`ifdef SEQ_CTRL_TIMEOUT_EN
          if (!x_valid) begin
            to_cnt_d = to_cnt + TO_W'(1);
            if (&to_cnt_d) begin
              state_d   = IDLE;
              timeout_d = 1'b1;
            end
          end
          if (state_d != state) to_cnt_d = '0;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pattern     <= '0;
      overlap     <= 1'b1;
      target      <= CNT_W'(1);
      match_count <= '0;
      match       <= 1'b0;
      cfg_err     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef SEQ_CTRL_TIMEOUT_EN
      to_cnt      <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      pattern     <= pattern_d;
      overlap     <= overlap_d;
      target      <= target_d;
      match_count <= count_d;
      match       <= match_d;
      cfg_err     <= cfg_err_d;
      busy        <= (state_d == FILL) || (state_d == RUN);
      done        <= (state_d == DONE);
`ifdef SEQ_CTRL_TIMEOUT_EN
      to_cnt      <= to_cnt_d;
      timeout     <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl with a sliding-window reference model.
module tb_seq_detect_ctrl;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic             start;
  logic             abort;
  logic             x_valid;
  logic             x;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;
  logic             cfg_err;
`ifdef SEQ_CTRL_TIMEOUT_EN
  logic             timeout;
`endif

  int checks = 0;
  int errors = 0;
  int dut_matches = 0;

  // Reference model: a window of the bits seen since arming (or since the last non-overlap match).
  logic [PAT_W-1:0] m_pat;
  logic             m_ovl;
  logic [CNT_W-1:0] m_tgt;
  logic [CNT_W-1:0] m_cnt;
  logic             m_busy;
  logic             m_done;
  bit               m_q[$];
  logic             exp_match;
  logic             exp_err;

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .x_valid     (x_valid),
    .x           (x),
    .match       (match),
    .match_count (match_count),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
`ifdef SEQ_CTRL_TIMEOUT_EN
    , .timeout   (timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pat = '0;
    m_ovl = 1'b1;
    m_tgt = CNT_W'(1);
    m_cnt = '0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_q.delete();
    exp_match = 1'b0;
    exp_err = 1'b0;
  endfunction

  function automatic void model_step();
    int v;
    exp_match = 1'b0;
    exp_err = 1'b0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (abort) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      return;
    end
    if (!m_busy) begin
      if (cfg_we) begin
        m_pat = cfg_pattern;
        m_ovl = cfg_overlap;
        m_tgt = cfg_target;
      end
      if (start) begin
        if (m_tgt == 0) exp_err = 1'b1;
        else begin
          m_q.delete();
          m_cnt = '0;
          m_busy = 1'b1;
          m_done = 1'b0;
        end
      end
    end else begin
      exp_err = cfg_we;
      if (x_valid) begin
        m_q.push_back(x);
        if (m_q.size() > PAT_W) void'(m_q.pop_front());
        if (m_q.size() == PAT_W) begin
          v = 0;
          foreach (m_q[i]) v = v * 2 + int'(m_q[i]);
          if (v == int'(m_pat)) begin
            exp_match = 1'b1;
            m_cnt = m_cnt + CNT_W'(1);
            if (m_cnt == m_tgt) begin
              m_busy = 1'b0;
              m_done = 1'b1;
            end else if (!m_ovl) begin
              m_q.delete();
            end
          end
        end
      end
    end
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("match", 32'(match), 32'(exp_match));
    chk("match_count", 32'(match_count), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("cfg_err", 32'(cfg_err), 32'(exp_err));
    if (match === 1'b1) dut_matches++;
  end

  task automatic cyc(input logic we = 1'b0, input logic st = 1'b0, input logic ab = 1'b0,
                     input logic xv = 1'b0, input logic xb = 1'b0);
    cfg_we = we;
    start = st;
    abort = ab;
    x_valid = xv;
    x = xb;
    @(posedge clk);
    model_step();
    #1;
    cfg_we = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    x_valid = 1'b0;
    x = 1'b0;
  endtask

  task automatic cfg(input logic [PAT_W-1:0] p, input logic o, input logic [CNT_W-1:0] t);
    cfg_pattern = p;
    cfg_overlap = o;
    cfg_target = t;
    cyc(1'b1);
  endtask

  task automatic bits(input string s);
    for (int i = 0; i < s.len(); i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, s.getc(i) == 8'h31);
  endtask

  initial begin
    reset_n = 1'b0;
    cfg_we = 1'b0;
    cfg_pattern = '0;
    cfg_overlap = 1'b0;
    cfg_target = '0;
    start = 1'b0;
    abort = 1'b0;
    x_valid = 1'b0;
    x = 1'b0;
    model_reset();
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);

    // Overlapping detection, target not reached; start while busy is ignored.
    dut_matches = 0;
    cfg(4'b0110, 1'b1, 8'd3);
    cyc(1'b0, 1'b1);
    bits("0110110");
    cyc(1'b0, 1'b1);
    chk("ovl_count", 32'(match_count), 32'd2);
    chk("ovl_pulses", 32'(dut_matches), 32'd2);
    chk("ovl_busy", 32'(busy), 32'd1);
    chk("ovl_done", 32'(done), 32'd0);
    cyc(1'b0, 1'b0, 1'b1);

    // Non-overlapping detection.
    dut_matches = 0;
    cfg(4'b0110, 1'b0, 8'd3);
    cyc(1'b0, 1'b1);
    bits("0110110");
    cyc();
    chk("novl_count", 32'(match_count), 32'd1);
    chk("novl_pulses", 32'(dut_matches), 32'd1);
    cyc(1'b0, 1'b0, 1'b1);

    // Completion on the second match; DONE ignores further bits.
    dut_matches = 0;
    cfg(4'b0110, 1'b1, 8'd2);
    cyc(1'b0, 1'b1);
    bits("011011");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fin_match", 32'(match), 32'd1);
    chk("fin_done", 32'(done), 32'd1);
    chk("fin_count", 32'(match_count), 32'd2);
    bits("0110");
    cyc();
    chk("fin_pulses", 32'(dut_matches), 32'd2);
    chk("fin_done_hold", 32'(done), 32'd1);

    // Write during RUN is rejected and leaves pattern and overlap untouched.
    cfg(4'b0110, 1'b1, 8'd3);
    cyc(1'b0, 1'b1);
    bits("0110");
    cfg(4'b1111, 1'b0, 8'd1);
    chk("run_we_err", 32'(cfg_err), 32'd1);
    cyc();
    chk("run_we_err_once", 32'(cfg_err), 32'd0);
    bits("110");
    cyc();
    chk("run_we_count", 32'(match_count), 32'd2);
    cyc(1'b0, 1'b0, 1'b1);

    // Zero target rejects start; same-edge write supplies a new target.
    cfg(4'b0110, 1'b1, 8'd0);
    cyc(1'b0, 1'b1);
    chk("zero_tgt_err", 32'(cfg_err), 32'd1);
    chk("zero_tgt_busy", 32'(busy), 32'd0);
    cfg_target = 8'd2;
    cyc(1'b1, 1'b1);
    chk("same_edge_busy", 32'(busy), 32'd1);
    chk("same_edge_err", 32'(cfg_err), 32'd0);

    // Abort with start and a completing bit discards the match and freezes the count.
    dut_matches = 0;
    bits("0110");
    bits("011");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("abort_match", 32'(match), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_count", 32'(match_count), 32'd1);
    cyc();
    chk("abort_pulses", 32'(dut_matches), 32'd1);

    // Asynchronous reset in the middle of RUN.
    cfg(4'b0110, 1'b1, 8'd3);
    cyc(1'b0, 1'b1);
    bits("0110");
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_match", 32'(match), 32'd0);
    chk("arst_count", 32'(match_count), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();

    // Reset configuration: pattern 0000, target 1.
    cyc(1'b0, 1'b1);
    bits("0000");
    cyc();
    chk("dflt_done", 32'(done), 32'd1);
    chk("dflt_count", 32'(match_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
